// File: rtl/vga_draw_pkg.sv
// Shared definitions for the VGA box-draw path: FSM state encoding and
// default screen geometry / pixel format.
package vga_draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } draw_state_t;

  localparam int NX_DEF          = 10;
  localparam int NY_DEF          = 9;
  localparam int COLOR_DEPTH_DEF = 9;
  localparam int XMAX_DEF        = 640;
  localparam int YMAX_DEF        = 480;

endpackage

// File: rtl/box_draw_arbiter_if.sv
// Request bus and pixel write port of the box-draw arbiter bundled as one
// interface; master = requesters side, slave = arbiter side.
interface box_draw_arbiter_if
  import vga_draw_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int nX          = NX_DEF,
  parameter int nY          = NY_DEF,
  parameter int COLOR_DEPTH = COLOR_DEPTH_DEF
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]             req;
  logic [NREQ*nX-1:0]          req_x;
  logic [NREQ*nX-1:0]          req_w;
  logic [NREQ*nY-1:0]          req_y;
  logic [NREQ*nY-1:0]          req_h;
  logic [NREQ*COLOR_DEPTH-1:0] req_color;
  logic [NREQ-1:0]             ack;
  logic                        busy;
  logic [IW-1:0]               grant_id;
  logic [nX-1:0]               vga_x;
  logic [nY-1:0]               vga_y;
  logic [COLOR_DEPTH-1:0]      vga_color;
  logic                        vga_write;

  modport master (
    output req, req_x, req_w, req_y, req_h, req_color,
    input  ack, busy, grant_id, vga_x, vga_y, vga_color, vga_write
  );

  modport slave (
    input  req, req_x, req_w, req_y, req_h, req_color,
    output ack, busy, grant_id, vga_x, vga_y, vga_color, vga_write
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after
// (last + 1) mod NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/box_draw_arbiter.sv
// Round-robin arbiter that grants one requester at a time and rasterises its
// box into the VGA pixel write port. Optional clipping: define BOX_CLIP_EN.
module box_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int nX          = NX_DEF,
  parameter int nY          = NY_DEF,
  parameter int COLOR_DEPTH = COLOR_DEPTH_DEF,
  parameter int XMAX        = XMAX_DEF,
  parameter int YMAX        = YMAX_DEF,
  localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        CLOCK_50,
  input  logic                        Resetn,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*nX-1:0]          req_x,
  input  logic [NREQ*nX-1:0]          req_w,
  input  logic [NREQ*nY-1:0]          req_y,
  input  logic [NREQ*nY-1:0]          req_h,
  input  logic [NREQ*COLOR_DEPTH-1:0] req_color,
  output logic [NREQ-1:0]             ack,
  output logic                        busy,
  output logic [IW-1:0]               grant_id,
  output logic [nX-1:0]               vga_x,
  output logic [nY-1:0]               vga_y,
  output logic [COLOR_DEPTH-1:0]      vga_color,
  output logic                        vga_write
);

  localparam logic [nX-1:0] X_ONE = 1;
  localparam logic [nY-1:0] Y_ONE = 1;

  draw_state_t state, state_n;

  logic [nX-1:0]          x0, w, xc, hold_x, pix_x;
  logic [nY-1:0]          y0, h, yc, hold_y, pix_y;
  logic [COLOR_DEPTH-1:0] color, hold_c;
  logic [IW-1:0]          last;
  logic                   grant_valid;
  logic [IW-1:0]          grant_idx;
  logic [nX-1:0]          sel_x, sel_w;
  logic [nY-1:0]          sel_y, sel_h;
  logic [COLOR_DEPTH-1:0] sel_c;
  logic                   x_end, y_end, in_bounds;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req         (req),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_x = req_x[grant_idx*nX +: nX];
  assign sel_w = req_w[grant_idx*nX +: nX];
  assign sel_y = req_y[grant_idx*nY +: nY];
  assign sel_h = req_h[grant_idx*nY +: nY];
  assign sel_c = req_color[grant_idx*COLOR_DEPTH +: COLOR_DEPTH];

  assign pix_x = x0 + xc;
  assign pix_y = y0 + yc;
  assign x_end = (xc == w - X_ONE);
  assign y_end = (yc == h - Y_ONE);

`ifdef BOX_CLIP_EN
  logic [nX:0] ux;
  logic [nY:0] uy;
  assign ux        = {1'b0, x0} + {1'b0, xc};
  assign uy        = {1'b0, y0} + {1'b0, yc};
  assign in_bounds = (int'(ux) < XMAX) && (int'(uy) < YMAX);
`else
  logic clip_unused;
  assign clip_unused = (XMAX < 0) | (YMAX < 0);
  assign in_bounds   = 1'b1;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      x0       <= '0;
      y0       <= '0;
      w        <= '0;
      h        <= '0;
      color    <= '0;
      xc       <= '0;
      yc       <= '0;
      grant_id <= '0;
      last     <= IW'(NREQ - 1);
      hold_x   <= '0;
      hold_y   <= '0;
      hold_c   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            x0       <= sel_x;
            y0       <= sel_y;
            w        <= sel_w;
            h        <= sel_h;
            color    <= sel_c;
            xc       <= '0;
            yc       <= '0;
            grant_id <= grant_idx;
          end
        end
        S_DRAW: begin
          // Hold regs keep the port stable once the draw ends.
          hold_x <= pix_x;
          hold_y <= pix_y;
          hold_c <= color;
          if (x_end) begin
            xc <= '0;
            yc <= yc + Y_ONE;
          end else begin
            xc <= xc + X_ONE;
          end
        end
        S_DONE: last <= grant_id;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (grant_valid)
          state_n = (sel_w == '0 || sel_h == '0) ? S_DONE : S_DRAW;
      end
      S_DRAW:  if (x_end && y_end) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state == S_DONE) ack[grant_id] = 1'b1;
  end

  assign busy      = (state != S_IDLE);
  assign vga_write = (state == S_DRAW) && in_bounds;
  assign vga_x     = (state == S_DRAW) ? pix_x : hold_x;
  assign vga_y     = (state == S_DRAW) ? pix_y : hold_y;
  assign vga_color = (state == S_DRAW) ? color : hold_c;

endmodule

// File: tb/tb_box_draw_arbiter.sv
// Directed bench for box_draw_arbiter: expected pixels queued when a box is
// requested and popped as the DUT writes them.
module tb_box_draw_arbiter;

  localparam int NREQ = 4;
  localparam int NX   = 10;
  localparam int NY   = 9;
  localparam int CD   = 9;

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  box_draw_arbiter_if #(.NREQ(NREQ), .nX(NX), .nY(NY), .COLOR_DEPTH(CD)) bif ();

  box_draw_arbiter dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .req       (bif.req),
    .req_x     (bif.req_x),
    .req_w     (bif.req_w),
    .req_y     (bif.req_y),
    .req_h     (bif.req_h),
    .req_color (bif.req_color),
    .ack       (bif.ack),
    .busy      (bif.busy),
    .grant_id  (bif.grant_id),
    .vga_x     (bif.vga_x),
    .vga_y     (bif.vga_y),
    .vga_color (bif.vga_color),
    .vga_write (bif.vga_write)
  );

  typedef struct packed {
    logic [NX-1:0] x;
    logic [NY-1:0] y;
    logic [CD-1:0] c;
  } pix_t;

  pix_t            exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              nbusy;
  int              nack;
  logic [NREQ-1:0] ack_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    pix_t p;
    @(posedge CLOCK_50);
    #1;
    if (bif.vga_write === 1'b1) begin
      p = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("pixel", {bif.vga_x, bif.vga_y, bif.vga_color}, p);
    end
    if (bif.ack !== '0) begin
      ack_seen = bif.ack;
      nack++;
    end
    if (bif.busy === 1'b1) nbusy++;
  endtask

  task automatic set_box(input int id, input int x, input int y, input int w,
                         input int h, input int c);
    bif.req_x[id*NX +: NX]     = NX'(x);
    bif.req_y[id*NY +: NY]     = NY'(y);
    bif.req_w[id*NX +: NX]     = NX'(w);
    bif.req_h[id*NY +: NY]     = NY'(h);
    bif.req_color[id*CD +: CD] = CD'(c);
  endtask

  task automatic push_box(input int x, input int y, input int w, input int h, input int c);
    pix_t p;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
`ifdef BOX_CLIP_EN
        if ((x + xx) < 640 && (y + yy) < 480) begin
`else
        begin
`endif
          p.x = NX'(x + xx);
          p.y = NY'(y + yy);
          p.c = CD'(c);
          exp_q.push_back(p);
        end
      end
  endtask

  // Grants one isolated request and follows it to its ack.
  task automatic run_one(input int id, input int w, input int h, input bit mutate);
    int t;
    nbusy    = 0;
    nack     = 0;
    ack_seen = '0;
    bif.req[id] = 1'b1;
    step();
    chk("grant_id", bif.grant_id, id);
    bif.req[id] = 1'b0;
    if (mutate) begin
      bif.req_x[id*NX +: NX] = NX'(999);
      bif.req_y[id*NY +: NY] = NY'(3);
    end
    t = 0;
    while (nack == 0 && t < 200) begin
      step();
      t++;
    end
    chk("ack_vec", ack_seen, 32'(1) << id);
    chk("draw_cycles", nbusy, w * h + 1);
    chk("pixels_left", exp_q.size(), 0);
    step();
    chk("idle_after", bif.busy, 0);
  endtask

  task automatic wait_grant();
    logic prev;
    int   t;
    prev = bif.busy;
    t    = 0;
    step();
    while (!(bif.busy === 1'b1 && prev === 1'b0) && t < 100) begin
      prev = bif.busy;
      step();
      t++;
    end
    chk("grant_seen", bif.busy, 1);
  endtask

  task automatic wait_ack();
    int t;
    nack     = 0;
    ack_seen = '0;
    t        = 0;
    while (nack == 0 && t < 100) begin
      step();
      t++;
    end
  endtask

  initial begin
    int last_m;
    int expg;
    int prevg;

    bif.req = '0; bif.req_x = '0; bif.req_y = '0;
    bif.req_w = '0; bif.req_h = '0; bif.req_color = '0;

    // Reset state
    step();
    step();
    chk("rst_busy", bif.busy, 0);
    chk("rst_ack", bif.ack, 0);
    chk("rst_write", bif.vga_write, 0);
    chk("rst_xyc", {bif.vga_x, bif.vga_y, bif.vga_color}, 0);
    chk("rst_gid", bif.grant_id, 0);
    Resetn = 1'b1;
    step();

    // 3x2 box on requester 0
    set_box(0, 10, 20, 3, 2, 9'h1C0);
    push_box(10, 20, 3, 2, 9'h1C0);
    run_one(0, 3, 2, 1'b0);
    chk("hold_xy", {bif.vga_x, bif.vga_y}, {10'd12, 9'd21});
    chk("hold_c", bif.vga_color, 9'h1C0);
    chk("hold_write", bif.vga_write, 0);

    // Zero-width box: ack right after grant, no pixels
    set_box(2, 5, 5, 0, 5, 9'h0AA);
    run_one(2, 0, 5, 1'b0);

    // Inputs dropped/changed mid-draw
    set_box(1, 100, 50, 2, 2, 9'h055);
    push_box(100, 50, 2, 2, 9'h055);
    run_one(1, 2, 2, 1'b1);

    // Box at the screen corner
    set_box(3, 638, 479, 4, 4, 9'h1FF);
    push_box(638, 479, 4, 4, 9'h1FF);
    run_one(3, 4, 4, 1'b0);

    // Round-robin fairness with all requesters held
    for (int k = 0; k < NREQ; k++) set_box(k, k * 10, 100, 1, 1, k + 1);
    last_m = 3;
    prevg  = -1;
    bif.req = '1;
    for (int g = 0; g < 5; g++) begin
      expg = (last_m + 1) % NREQ;
      push_box(expg * 10, 100, 1, 1, expg + 1);
      wait_grant();
      chk("rr_grant", bif.grant_id, expg);
      if (g > 0) chk("rr_repeat", (int'(bif.grant_id) != prevg), 1);
      prevg = int'(bif.grant_id);
      wait_ack();
      chk("rr_ack", ack_seen, 32'(1) << expg);
      last_m = expg;
    end
    bif.req = '0;
    step();
    step();
    chk("rr_pixels_left", exp_q.size(), 0);

    // Reset in the middle of a draw
    set_box(2, 0, 0, 4, 4, 9'h005);
    push_box(0, 0, 4, 4, 9'h005);
    bif.req = 4'b0100;
    step();
    chk("abort_grant", bif.grant_id, 2);
    step();
    step();
    step();
    nack   = 0;
    Resetn = 1'b0;
    step();
    chk("abort_write", bif.vga_write, 0);
    chk("abort_busy", bif.busy, 0);
    chk("abort_ack", bif.ack, 0);
    Resetn = 1'b1;
    exp_q.delete();
    set_box(0, 50, 60, 1, 1, 9'h007);
    push_box(50, 60, 1, 1, 9'h007);
    bif.req = 4'b0101;
    wait_grant();
    chk("post_rst_grant", bif.grant_id, 0);
    chk("abort_no_ack", nack, 0);
    wait_ack();
    chk("post_rst_ack", ack_seen, 4'b0001);
    bif.req = '0;
    step();
    step();
    chk("post_rst_pixels_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
